// File: rtl/pacman_sprite_reader_pkg.sv
// Shared sprite constants, direction codes and colours for the Pac-Man sprite readers.
// The mouth-mask helper is only used when PACMAN_MOUTH_ANIM_EN is defined.
package pacman_sprite_reader_pkg;

    localparam int PIXELS_WIDTH     = 80;
    localparam int REL_BITS         = 7;
    localparam int PIXEL_COLOR_BITS = 8;
    localparam int MOUTH_FRAMES     = 8;
    localparam int FRAME_CNT_BITS   = (MOUTH_FRAMES > 1) ? $clog2(MOUTH_FRAMES) : 1;

    localparam logic [PIXEL_COLOR_BITS-1:0] COLOR_BLACK  = 8'h00;
    localparam logic [PIXEL_COLOR_BITS-1:0] COLOR_YELLOW = 8'h3F;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    // Wedge opening to the right of the disc centre, in ROM coordinates.
    function automatic logic mouth_masked(input logic [REL_BITS-1:0] x,
                                          input logic [REL_BITS-1:0] y);
        logic signed [REL_BITS+1:0] ex;
        logic signed [REL_BITS+1:0] ey;
        logic signed [REL_BITS+1:0] ay;
        ex = $signed({2'b00, x}) - $signed((REL_BITS+2)'(PIXELS_WIDTH / 2));
        ey = $signed({2'b00, y}) - $signed((REL_BITS+2)'(PIXELS_WIDTH / 2));
        ay = (ey < 0) ? -ey : ey;
        return (ex >= 0) && (ay < ex);
    endfunction

endpackage

// File: rtl/pacman_dir_transform.sv
// Combinational facing-direction transform from box-relative (dx,dy) to graphic (rel_x,rel_y).
// Shared with the ghost renderer.
module pacman_dir_transform
    import pacman_sprite_reader_pkg::*;
(
    input  logic [REL_BITS-1:0] dx,
    input  logic [REL_BITS-1:0] dy,
    input  dir_e                dir,
    output logic [REL_BITS-1:0] rel_x,
    output logic [REL_BITS-1:0] rel_y
);

    localparam logic [REL_BITS-1:0] EDGE = REL_BITS'(PIXELS_WIDTH - 1);

    always_comb begin
        rel_x = dx;
        rel_y = dy;
        case (dir)
            DIR_RIGHT: begin
                rel_x = dx;
                rel_y = dy;
            end
            DIR_LEFT: begin
                rel_x = EDGE - dx;
                rel_y = dy;
            end
            DIR_DOWN: begin
                rel_x = dy;
                rel_y = dx;
            end
            DIR_UP: begin
                rel_x = dy;
                rel_y = EDGE - dx;
            end
            default: begin
                rel_x = dx;
                rel_y = dy;
            end
        endcase
    end

endmodule

// File: rtl/pacman_sprite_reader.sv
// Two-stage Pac-Man sprite read pipeline: scan position -> graphic lookup -> registered pixel.
// Optional mouth animation is enabled by defining PACMAN_MOUTH_ANIM_EN.
module pacman_sprite_reader
    import pacman_sprite_reader_pkg::*;
#(
    parameter int SCREEN_BITS = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pix_en,
    input  logic                        frame_start,
    input  logic [SCREEN_BITS-1:0]      hcount,
    input  logic [SCREEN_BITS-1:0]      vcount,
    input  logic [SCREEN_BITS-1:0]      pac_x,
    input  logic [SCREEN_BITS-1:0]      pac_y,
    input  logic [1:0]                  pac_dir,
    output logic [REL_BITS-1:0]         rel_x,
    output logic [REL_BITS-1:0]         rel_y,
    input  logic [PIXEL_COLOR_BITS-1:0] rom_pixel,
    output logic [PIXEL_COLOR_BITS-1:0] pixel_out,
    output logic                        pixel_hit,
    output logic                        pixel_valid
);

    localparam logic [SCREEN_BITS:0] BOX_W = (SCREEN_BITS+1)'(PIXELS_WIDTH);

    logic [SCREEN_BITS-1:0]      lx_q, lx_d, ly_q, ly_d;
    dir_e                        ldir_q, ldir_d;
    logic                        loaded_q, loaded_d;
    logic [REL_BITS-1:0]         rel_x_q, rel_x_d, rel_y_q, rel_y_d;
    logic                        s1_in_q, s1_in_d;
    logic [PIXEL_COLOR_BITS-1:0] pixel_out_q, pixel_out_d;
    logic                        pixel_hit_q, pixel_hit_d;
    logic                        pixel_valid_q, pixel_valid_d;

    logic [SCREEN_BITS:0]        h_ext, v_ext, lx_ext, ly_ext;
    logic [REL_BITS-1:0]         dx, dy, xf_x, xf_y;
    logic                        in_box;
    logic                        s1_masked;

    // A frame_start coinciding with pix_en feeds the freshly captured values straight into stage 0.
    always_comb begin
        lx_d     = lx_q;
        ly_d     = ly_q;
        ldir_d   = ldir_q;
        loaded_d = loaded_q;
        if (frame_start) begin
            lx_d     = pac_x;
            ly_d     = pac_y;
            ldir_d   = dir_e'(pac_dir);
            loaded_d = 1'b1;
        end
    end

    always_comb begin
        h_ext  = {1'b0, hcount};
        v_ext  = {1'b0, vcount};
        lx_ext = {1'b0, lx_d};
        ly_ext = {1'b0, ly_d};
        in_box = loaded_d
              && (h_ext >= lx_ext) && (h_ext < lx_ext + BOX_W)
              && (v_ext >= ly_ext) && (v_ext < ly_ext + BOX_W);
        dx = REL_BITS'(hcount - lx_d);
        dy = REL_BITS'(vcount - ly_d);
    end

    pacman_dir_transform u_transform (
        .dx    (dx),
        .dy    (dy),
        .dir   (ldir_d),
        .rel_x (xf_x),
        .rel_y (xf_y)
    );

    always_comb begin
        rel_x_d       = rel_x_q;
        rel_y_d       = rel_y_q;
        s1_in_d       = s1_in_q;
        pixel_out_d   = pixel_out_q;
        pixel_hit_d   = pixel_hit_q;
        pixel_valid_d = pix_en;
        if (pix_en) begin
            s1_in_d     = in_box;
            rel_x_d     = in_box ? xf_x : '0;
            rel_y_d     = in_box ? xf_y : '0;
            pixel_hit_d = s1_in_q && (rom_pixel != COLOR_BLACK) && !s1_masked;
            pixel_out_d = pixel_hit_d ? rom_pixel : COLOR_BLACK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lx_q          <= '0;
            ly_q          <= '0;
            ldir_q        <= DIR_RIGHT;
            loaded_q      <= 1'b0;
            rel_x_q       <= '0;
            rel_y_q       <= '0;
            s1_in_q       <= 1'b0;
            pixel_out_q   <= '0;
            pixel_hit_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
        end else begin
            lx_q          <= lx_d;
            ly_q          <= ly_d;
            ldir_q        <= ldir_d;
            loaded_q      <= loaded_d;
            rel_x_q       <= rel_x_d;
            rel_y_q       <= rel_y_d;
            s1_in_q       <= s1_in_d;
            pixel_out_q   <= pixel_out_d;
            pixel_hit_q   <= pixel_hit_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

`ifdef PACMAN_MOUTH_ANIM_EN
    logic [FRAME_CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;
    logic                      mouth_open_q, mouth_open_d;
    logic                      mask_q, mask_d;

    // Mask is evaluated on transformed coordinates so the mouth turns with the sprite.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        mouth_open_d = mouth_open_q;
        mask_d       = mask_q;
        if (frame_start) begin
            if (frame_cnt_q == FRAME_CNT_BITS'(MOUTH_FRAMES - 1)) begin
                frame_cnt_d  = '0;
                mouth_open_d = ~mouth_open_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_BITS'(1);
            end
        end
        if (pix_en) begin
            mask_d = in_box && mouth_open_d && mouth_masked(xf_x, xf_y);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= '0;
            mouth_open_q <= 1'b1;
            mask_q       <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            mouth_open_q <= mouth_open_d;
            mask_q       <= mask_d;
        end
    end

    assign s1_masked = mask_q;
`else
    assign s1_masked = 1'b0;
`endif

    assign rel_x       = rel_x_q;
    assign rel_y       = rel_y_q;
    assign pixel_out   = pixel_out_q;
    assign pixel_hit   = pixel_hit_q;
    assign pixel_valid = pixel_valid_q;

endmodule
